// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Writable instruction store and PC with a registered valid/ready
//            fetch, branch redirect, and halt/wrap detection.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                PC_BITS   = 12,
  parameter int                OP_W      = 3,
  parameter int                REG_W     = 3,
  parameter int                INSTR_W   = OP_W + 2*REG_W,
  parameter logic [OP_W-1:0]   HALT_OP   = 3'b111,
  parameter                    INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [PC_BITS-1:0] load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [PC_BITS-1:0] start_pc,
  input  logic               redirect_en,
  input  logic [PC_BITS-1:0] redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_W-1:0]   reg1,
  output logic [REG_W-1:0]   reg2,
  output logic [PC_BITS-1:0] out_pc,
  output logic [PC_BITS-1:0] pc,
  output logic               done
);

  localparam int                DEPTH   = 2**PC_BITS;
  localparam logic [PC_BITS-1:0] LAST_PC = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  state_t             state_q,     state_d;
  logic [PC_BITS-1:0] pc_q,        pc_d;
  logic [PC_BITS-1:0] out_pc_q,    out_pc_d;
  logic [OP_W-1:0]    opcode_q,    opcode_d;
  logic [REG_W-1:0]   reg1_q,      reg1_d;
  logic [REG_W-1:0]   reg2_q,      reg2_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q,      done_d;

  logic               mem_we;
  logic               accept;
  logic [INSTR_W-1:0] fetch_word;

  // Asynchronous read so a word loaded alongside start is visible to the first fetch.
  assign fetch_word = mem_q[pc_q];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    mem_we      = 1'b0;
    accept      = out_valid_q && out_ready;

    case (state_q)
      S_IDLE, S_DONE: begin
        mem_we = (state_q == S_IDLE) && load_en;
        if (start) begin
          state_d     = S_RUN;
          pc_d        = start_pc;
          out_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (redirect_en) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (accept && (opcode_q == HALT_OP || out_pc_q == LAST_PC)) begin
          // Halt word or last address consumed: stop without fetching further.
          state_d     = S_DONE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else if (!out_valid_q || out_ready) begin
          opcode_d    = fetch_word[INSTR_W-1 -: OP_W];
          reg1_d      = fetch_word[2*REG_W-1 -: REG_W];
          reg2_d      = fetch_word[REG_W-1:0];
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + PC_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      out_pc_q    <= '0;
      opcode_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Store is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign reg1      = reg1_q;
  assign reg2      = reg2_q;
  assign out_pc    = out_pc_q;
  assign pc        = pc_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed and randomized checks of instr_fetch_unit against a
//            cycle-level behavioural model (16-word store).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int         DEPTH  = 16;
  localparam logic [8:0] W_ADD  = 9'b001_010_011;
  localparam logic [8:0] W_HALT = 9'b111_000_000;
  localparam logic [8:0] W_FIVE = 9'b100_001_110;

  logic       clk = 1'b0;
  logic       reset, load_en, start, redirect_en, out_ready;
  logic [3:0] load_addr, start_pc, redirect_pc;
  logic [8:0] load_data;
  logic       out_valid, done;
  logic [2:0] opcode, reg1, reg2;
  logic [3:0] out_pc, pc;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  int         m_mode, m_pc, m_out_pc;
  bit         m_valid, m_done;
  logic [8:0] m_word;
  logic [8:0] m_mem [DEPTH];

  instr_fetch_unit #(.PC_BITS(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_pc(start_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .opcode(opcode), .reg1(reg1), .reg2(reg2),
    .out_pc(out_pc), .pc(pc), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0; m_pc <= 0; m_out_pc <= 0; m_word <= '0; m_valid <= 1'b0; m_done <= 1'b0;
    end else if (m_mode != 1) begin
      if (m_mode == 0 && load_en) m_mem[load_addr] <= load_data;
      if (start) begin
        m_mode <= 1; m_pc <= int'(start_pc); m_valid <= 1'b0; m_done <= 1'b0;
      end
    end else if (redirect_en) begin
      m_pc <= int'(redirect_pc); m_valid <= 1'b0;
    end else if (m_valid && out_ready && (m_word[8:6] == 3'b111 || m_out_pc == DEPTH-1)) begin
      m_mode <= 2; m_valid <= 1'b0; m_done <= 1'b1;
    end else if (!m_valid || out_ready) begin
      m_word   <= m_mem[m_pc[3:0]];
      m_out_pc <= m_pc;
      m_valid  <= 1'b1;
      m_pc     <= (m_pc + 1) % DEPTH;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({out_valid, opcode, reg1, reg2, out_pc, pc, done} !==
          {m_valid, m_word, 4'(m_out_pc), 4'(m_pc), m_done}) begin
        failures++;
        $display("FAIL model_compare t=%0t got v=%b op=%0d r1=%0d r2=%0d out_pc=%0d pc=%0d done=%b want v=%b word=%b out_pc=%0d pc=%0d done=%b",
                 $time, out_valid, opcode, reg1, reg2, out_pc, pc, done,
                 m_valid, m_word, m_out_pc, m_pc, m_done);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    int last_pc;
    reset = 1'b1; load_en = 1'b0; start = 1'b0; redirect_en = 1'b0; out_ready = 1'b0;
    load_addr = '0; start_pc = '0; redirect_pc = '0; load_data = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_pc", int'(pc), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      load_en   = 1'b1;
      load_addr = 4'(a);
      if (a < 3)       load_data = W_ADD;
      else if (a == 3) load_data = W_HALT;
      else if (a == 5) load_data = W_FIVE;
      else             load_data = {3'($urandom_range(0, 6)), 6'($urandom)};
      cyc();
    end
    load_en = 1'b0;

    // Straight-line program ending in a halt word.
    start = 1'b1; start_pc = 4'd0; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_entry_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("seq_out_pc", int'(out_pc), i);
      chk("seq_opcode", int'(opcode), (i < 3) ? 1 : 7);
      if (i < 3) begin
        chk("seq_reg1", int'(reg1), 2);
        chk("seq_reg2", int'(reg2), 3);
      end
    end
    cyc();
    chk("halt_done", int'(done), 1);
    chk("halt_valid", int'(out_valid), 0);
    chk("model_halt_done", int'(m_done), 1);

    // Back-pressure holds the presented word and pc.
    start = 1'b1; start_pc = 4'd0;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("pre_stall_out_pc", int'(out_pc), 1);
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("stall_out_pc", int'(out_pc), 1);
      chk("stall_pc", int'(pc), 2);
      chk("stall_opcode", int'(opcode), 1);
    end
    out_ready = 1'b1;
    cyc();
    chk("post_stall_out_pc", int'(out_pc), 2);

    // Redirect discards the word on display, then the stream runs to the wrap.
    redirect_en = 1'b1; redirect_pc = 4'd8;
    cyc();
    redirect_en = 1'b0;
    chk("redir_valid", int'(out_valid), 0);
    chk("redir_pc", int'(pc), 8);
    cyc();
    chk("redir_out_pc", int'(out_pc), 8);
    seen_done = 1'b0; last_pc = -1;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      if (out_valid) last_pc = int'(out_pc);
      cyc();
      seen_done = done;
    end
    chk("wrap_done_reached", int'(seen_done), 1);
    chk("wrap_last_out_pc", last_pc, 15);
    chk("wrap_pc", int'(pc), 0);

    // Wrap from a start near the top of the store.
    start = 1'b1; start_pc = 4'd14;
    cyc();
    start = 1'b0;
    cyc();
    chk("wrap14_out_pc", int'(out_pc), 14);
    cyc();
    chk("wrap15_out_pc", int'(out_pc), 15);
    cyc();
    chk("wrap_end_done", int'(done), 1);
    chk("wrap_end_pc", int'(pc), 0);
    chk("wrap_end_valid", int'(out_valid), 0);

    // Reset in the middle of a stream; store survives.
    start = 1'b1; start_pc = 4'd0;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("mid_valid", int'(out_valid), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mreset_all", int'({out_valid, opcode, reg1, reg2, out_pc, pc, done}), 0);
    start = 1'b1; start_pc = 4'd0;
    cyc();
    start = 1'b0;
    cyc();
    chk("restart_word", int'({opcode, reg1, reg2}), int'(W_ADD));
    chk("restart_out_pc", int'(out_pc), 0);

    // Loads are ignored while running.
    load_en = 1'b1; load_addr = 4'd5; load_data = 9'b010_101_101;
    cyc();
    load_en = 1'b0;
    redirect_en = 1'b1; redirect_pc = 4'd5;
    cyc();
    redirect_en = 1'b0;
    cyc();
    chk("run_load_out_pc", int'(out_pc), 5);
    chk("run_load_word", int'({opcode, reg1, reg2}), int'(W_FIVE));

    // Redirect coincident with halt accept keeps running.
    redirect_en = 1'b1; redirect_pc = 4'd3;
    cyc();
    redirect_en = 1'b0;
    cyc();
    chk("halt_word_op", int'(opcode), 7);
    redirect_en = 1'b1; redirect_pc = 4'd8;
    cyc();
    redirect_en = 1'b0;
    chk("redir_halt_done", int'(done), 0);
    chk("redir_halt_valid", int'(out_valid), 0);
    cyc();
    chk("redir_halt_out_pc", int'(out_pc), 8);

    // Randomized traffic; the model compare runs every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = 4'($urandom);
      load_data   = 9'($urandom);
      start       = ($urandom_range(0, 11) == 0);
      start_pc    = 4'($urandom);
      redirect_en = ($urandom_range(0, 9) == 0);
      redirect_pc = 4'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
